// File: rtl/vending_credit_manager.sv
// Vending credit manager: accumulates coin credit, dispenses affordable items and tracks refunds.
// Per-item stock counters are built only when VENDING_STOCK_TRACK_EN is defined.
module vending_credit_manager #(
  parameter int kNumCoins  = 3,
  parameter int kNumItems  = 4,
  parameter int kTotalBits = 31,
  parameter int kStockInit = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [kNumCoins-1:0]  i_input_coin,
  input  logic [kNumItems-1:0]  i_select_item,
  input  logic [kNumCoins-1:0]  i_return_coin,
  output logic [kTotalBits-1:0] o_current_total,
  output logic [kNumItems-1:0]  o_available_item,
  output logic [kNumItems-1:0]  o_output_item,
  output logic                  o_reject_coin,
  output logic                  o_busy
);

  typedef logic [kTotalBits-1:0] total_t;
  typedef enum logic [1:0] {IDLE, CREDIT, RETURN} state_t;

  if (kStockInit < 0 || kStockInit > 15 || kTotalBits < 12) begin : g_param_check
    $error("kStockInit must fit 4 bits and kTotalBits must hold the largest price");
  end

  function automatic total_t coin_value(input int idx);
    case (idx)
      0:       coin_value = total_t'(100);
      1:       coin_value = total_t'(500);
      2:       coin_value = total_t'(1000);
      default: coin_value = '0;
    endcase
  endfunction

  function automatic total_t item_price(input int idx);
    case (idx)
      0:       item_price = total_t'(400);
      1:       item_price = total_t'(500);
      2:       item_price = total_t'(1000);
      3:       item_price = total_t'(2000);
      default: item_price = '1;
    endcase
  endfunction

  state_t                 state_q, state_d;
  total_t                 credit_q, credit_d;
  total_t                 coin_sum, refund_sum, price_sum, base, after_buy;
  logic   [kTotalBits:0]  sum_add;
  logic   [kNumItems-1:0] in_stock, available, grant;
  logic                   coin_req, refund_req, reject_d, accept, found;

  always_comb begin
    coin_sum   = '0;
    refund_sum = '0;
    for (int i = 0; i < kNumCoins; i++) begin
      if (i_input_coin[i])  coin_sum   = coin_sum + coin_value(i);
      if (i_return_coin[i]) refund_sum = refund_sum + coin_value(i);
    end
  end

`ifdef VENDING_STOCK_TRACK_EN
  logic [3:0] stock_q [kNumItems];

  always_ff @(posedge clk) begin
    for (int i = 0; i < kNumItems; i++) begin
      if (!reset_n) begin
        stock_q[i] <= 4'(kStockInit);
      end else if (grant[i] && stock_q[i] != 4'd0) begin
        stock_q[i] <= stock_q[i] - 4'd1;
      end
    end
  end

  always_comb begin
    in_stock = '0;
    for (int i = 0; i < kNumItems; i++) in_stock[i] = (stock_q[i] != 4'd0);
  end
`else
  assign in_stock = '1;
`endif

  always_comb begin
    available = '0;
    for (int i = 0; i < kNumItems; i++) begin
      available[i] = (credit_q >= item_price(i)) && in_stock[i];
    end
  end

  assign coin_req   = |i_input_coin;
  assign refund_req = |i_return_coin;

  // Carry out of the credit+coin sum is the overflow condition.
  assign sum_add  = {1'b0, credit_q} + {1'b0, coin_sum};
  assign reject_d = coin_req && ((state_q == RETURN) || sum_add[kTotalBits]);
  assign accept   = coin_req && !reject_d;

  always_comb begin
    grant     = '0;
    found     = 1'b0;
    price_sum = '0;
    if (state_q != RETURN && !refund_req) begin
      for (int i = 0; i < kNumItems; i++) begin
        if (!found && i_select_item[i] && available[i]) begin
          grant[i]  = 1'b1;
          found     = 1'b1;
          price_sum = item_price(i);
        end
      end
    end
  end

  // A grant implies credit_q >= price, so after_buy never underflows; refunds clamp at zero.
  always_comb begin
    base      = accept ? sum_add[kTotalBits-1:0] : credit_q;
    after_buy = base - price_sum;
    credit_d  = (refund_sum >= after_buy) ? '0 : after_buy - refund_sum;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (credit_d != '0) state_d = CREDIT;
      end
      CREDIT: begin
        if (refund_req)            state_d = RETURN;
        else if (credit_d == '0)   state_d = IDLE;
      end
      RETURN: begin
        if (credit_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      credit_q      <= '0;
      o_output_item <= '0;
      o_reject_coin <= 1'b0;
    end else begin
      credit_q      <= credit_d;
      o_output_item <= grant;
      o_reject_coin <= reject_d;
    end
  end

  assign o_current_total  = credit_q;
  assign o_available_item = available;
  assign o_busy           = (state_q == RETURN);

endmodule

// File: tb/tb_vending_credit_manager.sv
// Bench for vending_credit_manager: directed vector table, hand sequences and a randomized
// run, all compared against an arithmetic reference model (one per DUT instance).
module tb_vending_credit_manager;

`ifdef VENDING_STOCK_TRACK_EN
  localparam bit kTrack   = 1'b1;
  localparam int kTbStock = 1;
`else
  localparam bit kTrack   = 1'b0;
  localparam int kTbStock = 8;
`endif

  logic        clk;
  logic        reset_n;
  logic [2:0]  i_input_coin, i_return_coin;
  logic [3:0]  i_select_item;
  logic [30:0] tot0;
  logic [11:0] tot1;
  logic [3:0]  av0, av1, item0, item1;
  logic        rej0, rej1, busy0, busy1;

  vending_credit_manager #(.kStockInit(kTbStock)) dut (
    .clk(clk), .reset_n(reset_n), .i_input_coin(i_input_coin),
    .i_select_item(i_select_item), .i_return_coin(i_return_coin),
    .o_current_total(tot0), .o_available_item(av0), .o_output_item(item0),
    .o_reject_coin(rej0), .o_busy(busy0)
  );

  vending_credit_manager #(.kTotalBits(12), .kStockInit(kTbStock)) dut_s (
    .clk(clk), .reset_n(reset_n), .i_input_coin(i_input_coin),
    .i_select_item(i_select_item), .i_return_coin(i_return_coin),
    .o_current_total(tot1), .o_available_item(av1), .o_output_item(item1),
    .o_reject_coin(rej1), .o_busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit primed   = 1'b0;

  int     kCoin  [3] = '{100, 500, 1000};
  int     kPrice [4] = '{400, 500, 1000, 2000};
  longint m_max    [2];
  longint m_credit [2];
  bit     m_busy   [2];
  int     m_stock  [2][4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic longint coin_total(input logic [2:0] c);
    longint s = 0;
    for (int i = 0; i < 3; i++) if (c[i]) s += kCoin[i];
    return s;
  endfunction

  function automatic logic [3:0] model_avail(input int k);
    logic [3:0] a = '0;
    for (int i = 0; i < 4; i++)
      a[i] = (m_credit[k] >= kPrice[i]) && (!kTrack || m_stock[k][i] > 0);
    return a;
  endfunction

  task automatic model_step(input int k, input logic [2:0] c, input logic [3:0] s,
                            input logic [2:0] r, input bit rst,
                            output logic [3:0] item, output bit rej);
    logic [3:0] av;
    longint     cs, rs, newc;
    int         pick;
    item = '0;
    rej  = 1'b0;
    if (rst) begin
      m_credit[k] = 0;
      m_busy[k]   = 1'b0;
      for (int i = 0; i < 4; i++) m_stock[k][i] = kTbStock;
      return;
    end
    av   = model_avail(k);
    cs   = coin_total(c);
    rs   = coin_total(r);
    rej  = (c != 0) && (m_busy[k] || m_credit[k] + cs > m_max[k]);
    pick = -1;
    if (!m_busy[k] && r == 0)
      for (int i = 0; i < 4; i++) if (pick < 0 && s[i] && av[i]) pick = i;
    newc = m_credit[k] + ((c != 0 && !rej) ? cs : 0);
    if (pick >= 0) begin
      newc -= kPrice[pick];
      item[pick] = 1'b1;
      if (kTrack) m_stock[k][pick]--;
    end
    newc = (newc > rs) ? newc - rs : 0;
    m_busy[k]   = m_busy[k] ? (newc != 0) : (r != 0 && m_credit[k] > 0);
    m_credit[k] = newc;
  endtask

  task automatic step(input logic [2:0] c, input logic [3:0] s, input logic [2:0] r, input bit rst);
    logic [3:0] ei [2];
    bit         er [2];
    i_input_coin  = c;
    i_select_item = s;
    i_return_coin = r;
    reset_n       = !rst;
    #1;
    if (primed) begin
      chk("avail_pre", av0, model_avail(0));
      chk("avail_pre_s", av1, model_avail(1));
    end
    for (int k = 0; k < 2; k++) model_step(k, c, s, r, rst, ei[k], er[k]);
    @(posedge clk);
    #1;
    primed = 1'b1;
    chk("total", tot0, m_credit[0]);
    chk("item", item0, ei[0]);
    chk("reject", rej0, er[0]);
    chk("busy", busy0, m_busy[0]);
    chk("avail", av0, model_avail(0));
    chk("total_s", tot1, m_credit[1]);
    chk("item_s", item1, ei[1]);
    chk("reject_s", rej1, er[1]);
    chk("busy_s", busy1, m_busy[1]);
    chk("avail_s", av1, model_avail(1));
  endtask

  typedef struct {
    logic [2:0] c;
    logic [3:0] s;
    logic [2:0] r;
    bit         rst;
    int         total;
    logic [3:0] item;
    bit         rej;
    bit         busy;
    logic [3:0] av;
    bit         avc;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] c, input logic [3:0] s, input logic [2:0] r,
                              input bit rst, input int total, input logic [3:0] item,
                              input bit rej, input bit busy, input logic [3:0] av, input bit avc);
    vec_t v;
    v.c = c; v.s = s; v.r = r; v.rst = rst; v.total = total; v.item = item;
    v.rej = rej; v.busy = busy; v.av = av; v.avc = avc;
    return v;
  endfunction

  initial begin
    vec_t       tbl [$];
    logic [2:0] oc  [10] = '{3'b111, 3'b111, 3'b110, 3'b010, 3'b010,
                             3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
    int         ot  [10] = '{1600, 3200, 3200, 3700, 3700, 3800, 3900, 4000, 4000, 4000};
    bit         orj [10] = '{0, 0, 1, 0, 1, 0, 0, 0, 1, 0};

    m_max[0] = 64'd2147483647;
    m_max[1] = 64'd4095;
    i_input_coin = '0; i_select_item = '0; i_return_coin = '0; reset_n = 1'b0;

    //            coin    sel      ret    rst total item     rej busy avail  chk
    tbl.push_back(mk(3'b000, 4'b0000, 3'b000, 1,    0, 4'b0000, 0, 0, 4'b0000, 1));
    tbl.push_back(mk(3'b110, 4'b0000, 3'b000, 0, 1500, 4'b0000, 0, 0, 4'b0111, 1));
    tbl.push_back(mk(3'b000, 4'b0110, 3'b000, 0, 1000, 4'b0010, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(3'b001, 4'b0100, 3'b000, 0,  100, 4'b0100, 0, 0, 4'b0000, 1));
    tbl.push_back(mk(3'b110, 4'b0000, 3'b000, 0, 1600, 4'b0000, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(3'b000, 4'b0000, 3'b101, 0,  500, 4'b0000, 0, 1, 4'b0000, 0));
    tbl.push_back(mk(3'b000, 4'b0000, 3'b010, 0,    0, 4'b0000, 0, 0, 4'b0000, 1));
    tbl.push_back(mk(3'b111, 4'b0000, 3'b000, 0, 1600, 4'b0000, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(3'b000, 4'b0000, 3'b001, 0, 1500, 4'b0000, 0, 1, 4'b0000, 0));
    tbl.push_back(mk(3'b010, 4'b0000, 3'b000, 0, 1500, 4'b0000, 1, 1, 4'b0000, 0));
    tbl.push_back(mk(3'b000, 4'b0001, 3'b000, 0, 1500, 4'b0000, 0, 1, 4'b0000, 0));
    tbl.push_back(mk(3'b000, 4'b0000, 3'b100, 0,  500, 4'b0000, 0, 1, 4'b0000, 0));
    tbl.push_back(mk(3'b000, 4'b0000, 3'b010, 0,    0, 4'b0000, 0, 0, 4'b0000, 1));
    tbl.push_back(mk(3'b001, 4'b0000, 3'b000, 0,  100, 4'b0000, 0, 0, 4'b0000, 1));
    tbl.push_back(mk(3'b000, 4'b0000, 3'b100, 0,    0, 4'b0000, 0, 1, 4'b0000, 1));
    tbl.push_back(mk(3'b000, 4'b0000, 3'b000, 0,    0, 4'b0000, 0, 0, 4'b0000, 1));
    tbl.push_back(mk(3'b100, 4'b0000, 3'b000, 0, 1000, 4'b0000, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(3'b000, 4'b0000, 3'b001, 0,  900, 4'b0000, 0, 1, 4'b0000, 0));
    tbl.push_back(mk(3'b100, 4'b0000, 3'b001, 1,    0, 4'b0000, 0, 0, 4'b0000, 1));
    tbl.push_back(mk(3'b100, 4'b0000, 3'b000, 0, 1000, 4'b0000, 0, 0, 4'b0111, 1));
    tbl.push_back(mk(3'b001, 4'b0001, 3'b000, 1,    0, 4'b0000, 0, 0, 4'b0000, 1));
    tbl.push_back(mk(3'b111, 4'b0001, 3'b000, 0, 1600, 4'b0000, 0, 0, 4'b0111, 1));
    tbl.push_back(mk(3'b000, 4'b1000, 3'b000, 0, 1600, 4'b0000, 0, 0, 4'b0111, 1));
    tbl.push_back(mk(3'b010, 4'b1000, 3'b000, 0, 2100, 4'b0000, 0, 0, 4'b1111, 1));
    tbl.push_back(mk(3'b000, 4'b1000, 3'b000, 0,  100, 4'b1000, 0, 0, 4'b0000, 1));
    tbl.push_back(mk(3'b001, 4'b0001, 3'b000, 0,  200, 4'b0000, 0, 0, 4'b0000, 1));
    tbl.push_back(mk(3'b100, 4'b0000, 3'b000, 0, 1200, 4'b0000, 0, 0, 4'b0111, 1));
    tbl.push_back(mk(3'b000, 4'b0001, 3'b001, 0, 1100, 4'b0000, 0, 1, 4'b0111, 1));
    tbl.push_back(mk(3'b000, 4'b0000, 3'b100, 0,  100, 4'b0000, 0, 1, 4'b0000, 1));
    tbl.push_back(mk(3'b000, 4'b0000, 3'b001, 0,    0, 4'b0000, 0, 0, 4'b0000, 1));

    foreach (tbl[i]) begin
      step(tbl[i].c, tbl[i].s, tbl[i].r, tbl[i].rst);
      chk($sformatf("tbl%0d_total", i), tot0, 64'(tbl[i].total));
      chk($sformatf("tbl%0d_item", i), item0, tbl[i].item);
      chk($sformatf("tbl%0d_reject", i), rej0, tbl[i].rej);
      chk($sformatf("tbl%0d_busy", i), busy0, tbl[i].busy);
      if (tbl[i].avc) chk($sformatf("tbl%0d_avail", i), av0, tbl[i].av);
    end

    // Credit ceiling on the 12-bit instance (max 4095).
    step(3'b000, 4'b0000, 3'b000, 1);
    for (int i = 0; i < 10; i++) begin
      step(oc[i], 4'b0000, 3'b000, 0);
      chk($sformatf("ovf%0d_total", i), tot1, 64'(ot[i]));
      chk($sformatf("ovf%0d_reject", i), rej1, orj[i]);
    end

`ifdef VENDING_STOCK_TRACK_EN
    step(3'b000, 4'b0000, 3'b000, 1);
    step(3'b100, 4'b0000, 3'b000, 0);
    chk("stock_total0", tot0, 64'd1000);
    step(3'b000, 4'b0001, 3'b000, 0);
    chk("stock_item1", item0, 4'b0001);
    chk("stock_total1", tot0, 64'd600);
    chk("stock_avail0", av0[0], 1'b0);
    step(3'b000, 4'b0001, 3'b000, 0);
    chk("stock_item2", item0, 4'b0000);
    chk("stock_total2", tot0, 64'd600);
`endif

    for (int n = 0; n < 2500; n++) begin
      logic [2:0] c, r;
      logic [3:0] s;
      bit         rst;
      c   = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      s   = 4'($urandom_range(0, 15));
      r   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      rst = ($urandom_range(0, 99) == 0);
      step(c, s, r, rst);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vending_credit_manager.md
VENDING_CREDIT_MANAGER -- requirements
Module: vending_credit_manager

Interface
REQ-001 Parameters SHALL be (name, default, meaning): kNumCoins, 3, coin types; kNumItems, 4, item types; kTotalBits, 31, credit width; kStockInit, 8, per-item stock after reset.
REQ-002 Coin values SHALL be 100/500/1000 (index 0/1/2) and item prices 400/500/1000/2000 (index 0..3), as fixed constants.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock, rising edge.
- reset_n, in, 1, synchronous active-low reset.
- i_input_coin, in, kNumCoins, coins inserted this cycle, any bit combination.
- i_select_item, in, kNumItems, item request this cycle.
- i_return_coin, in, kNumCoins, coins being returned by the downstream timer/return stage this cycle.
- o_current_total, out, kTotalBits, registered credit, feeds the return stage.
- o_available_item, out, kNumItems, combinational: item affordable and in stock.
- o_output_item, out, kNumItems, registered one-cycle dispense pulse, also feeds the return stage's wait timer.
- o_reject_coin, out, 1, registered one-cycle pulse: insertion refused.
- o_busy, out, 1, high in RETURN state.

Function
REQ-004 State machine SHALL have states IDLE (credit 0), CREDIT (credit >0) and RETURN (refund in progress).
REQ-005 Transitions SHALL be:
- IDLE->CREDIT on accepted coin.
- CREDIT->RETURN when i_return_coin != 0.
- RETURN->IDLE when next credit is 0.
- CREDIT->IDLE when a dispense leaves credit 0.
REQ-006 In IDLE/CREDIT, accepted coins SHALL add the sum of asserted coin values to credit at the next edge (latency 1).
REQ-007 A coin insertion SHALL be rejected whole, with o_reject_coin pulsed next cycle and credit unchanged, if credit plus insertion would exceed 2^kTotalBits-1, or if it arrives in RETURN state.
REQ-008 o_available_item[i] SHALL be 1 iff o_current_total >= price[i] and item i is in stock.
REQ-009 On i_select_item, only the lowest-index asserted bit that is also available SHALL be dispensed; o_output_item SHALL be its one-hot pulse next cycle and its price SHALL be subtracted.
REQ-010 Unavailable selections SHALL be ignored with no pulse.
REQ-011 Coin add and dispense in the same cycle SHALL both apply: next = credit + coins - price. Availability SHALL be judged on the pre-edge credit.
REQ-012 When i_return_coin != 0, the sum of its coin values SHALL be subtracted. Selection SHALL be ignored that cycle and in RETURN state.
REQ-013 A refund exceeding credit SHALL clamp credit to 0 (no wrap-around).
REQ-014 o_output_item and o_reject_coin SHALL be 0 on every cycle without a qualifying event.

Reset
REQ-015 While reset_n=0 at a clk edge: state IDLE, credit 0, o_output_item 0, o_reject_coin 0, o_busy 0, all stock = kStockInit. Reset SHALL override all inputs, including mid-refund and mid-dispense.

Configuration
REQ-016 Macro VENDING_STOCK_TRACK_EN SHALL control stock tracking:
- Defined: each item has a 4-bit stock counter, decremented on dispense. Stock 0 forces availability 0. Counters never wrap below 0.
- Undefined: no counters; stock is treated as unlimited and REQ-008 uses price only.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Reset, then coins 3'b110 in one cycle -> total 1500 next cycle, state CREDIT, o_available_item 4'b0111.
- Total 1500, select 4'b0110 -> o_output_item 4'b0010, total 1000.
- Total 1000, coin 3'b001 plus select 4'b0100 in the same cycle -> o_output_item 4'b0100, total 100.
- Total 1600, i_return_coin 3'b101 -> total 500, o_busy 1; next i_return_coin 3'b010 -> total 0, IDLE. A coin inserted in RETURN -> o_reject_coin pulse, total unchanged.
- With VENDING_STOCK_TRACK_EN defined, kStockInit 1, two affordable selections of item 0 -> first dispenses, second ignored, o_available_item[0]=0.
- Total 2^31-200, coin 3'b100 -> o_reject_coin 1, total unchanged. Reset asserted mid-RETURN -> total 0, IDLE.
